// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared FSM state encoding and default timing constants for input_conditioner
package input_cond_pkg;
    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;
    localparam int DEF_SAMPLE_CNT_MAX = 62500;
    localparam int DEF_PULSE_CNT_MAX = 200;
endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: per-channel saturating sample counter and press/release FSM (release pulse under INPUT_COND_RELEASE_PULSE_EN)
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int PULSE_CNT_MAX = DEF_PULSE_CNT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_lvl,
    input  logic sample_tick,
    output logic debounced,
    output logic press,
    output logic release_p
);
    localparam int CW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(PULSE_CNT_MAX);
    logic [CW-1:0] cnt;
    state_t state;
    // count consecutive high samples, saturating; any low cycle clears
    always_ff @(posedge clk)
        cnt <= (rst || !sync_lvl) ? '0 : (sample_tick && cnt != CNT_TOP) ? cnt + CW'(1) : cnt;
    // press once the counter is full; release as soon as the synced level drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RELEASED;
            press <= 1'b0;
        end else begin
            press <= state == RELEASED && cnt == CNT_TOP;
            state <= (state == RELEASED && cnt == CNT_TOP) ? PRESSED :
                     (state == PRESSED && !sync_lvl) ? RELEASED : state;
        end
    end
    assign debounced = state == PRESSED;
`ifdef INPUT_COND_RELEASE_PULSE_EN
    // one-cycle pulse on the PRESSED -> RELEASED transition; reset never produces one
    always_ff @(posedge clk)
        release_p <= !rst && state == PRESSED && !sync_lvl;
`else
    assign release_p = 1'b0;
`endif
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces and edge-detects WIDTH raw inputs (release pulse under INPUT_COND_RELEASE_PULSE_EN)
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX = DEF_PULSE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);
    localparam int SW = $clog2(SAMPLE_CNT_MAX);
    logic [WIDTH-1:0] sync_meta, sync_lvl;
    logic [SW-1:0] sample_cnt;
    logic sample_tick;
    // two-flop synchronizer for every raw input bit
    always_ff @(posedge clk) begin
        sync_meta <= rst ? '0 : async_in;
        sync_lvl <= rst ? '0 : sync_meta;
    end
    // shared sample counter, wraps after the tick cycle
    always_ff @(posedge clk)
        sample_cnt <= (rst || sample_tick) ? '0 : sample_cnt + SW'(1);
    assign sample_tick = sample_cnt == SW'(SAMPLE_CNT_MAX - 1);
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(.PULSE_CNT_MAX(PULSE_CNT_MAX)) u_ch (
            .clk(clk),
            .rst(rst),
            .sync_lvl(sync_lvl[g]),
            .sample_tick(sample_tick),
            .debounced(debounced_out[g]),
            .press(press_pulse[g]),
            .release_p(release_pulse[g])
        );
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus checked against a cycle model of the conditioner rules
module tb_input_conditioner;
    localparam int W = 2, S = 4, P = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic [W-1:0] ain = '0;
    logic [W-1:0] debounced_out, press_pulse, release_pulse;
    int total = 0, bad = 0;
    int np0 = 0, nr0 = 0, nb = 0;
    int scnt = 0;
    int mc[W];
    bit mp[W];
    logic [W-1:0] d1 = '0, d2 = '0, e_deb = '0, e_pr = '0, e_rl = '0;

    input_conditioner #(.WIDTH(W), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P)) dut (
        .clk(clk),
        .rst(rst),
        .async_in(ain),
        .debounced_out(debounced_out),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rl_exp();
`ifdef INPUT_COND_RELEASE_PULSE_EN
        return e_rl;
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance the reference by one rising edge using the pre-edge inputs
    task automatic upd();
        if (rst) begin
            scnt = 0; d1 = '0; d2 = '0; e_deb = '0; e_pr = '0; e_rl = '0;
            for (int i = 0; i < W; i++) begin mc[i] = 0; mp[i] = 0; end
        end else begin
            bit tick;
            tick = scnt == S - 1;
            for (int i = 0; i < W; i++) begin
                e_pr[i] = 1'b0;
                e_rl[i] = 1'b0;
                if (!mp[i] && mc[i] == P) begin mp[i] = 1; e_pr[i] = 1'b1; end
                else if (mp[i] && !d2[i]) begin mp[i] = 0; e_rl[i] = 1'b1; end
                if (!d2[i]) mc[i] = 0;
                else if (tick && mc[i] < P) mc[i] = mc[i] + 1;
                e_deb[i] = mp[i];
            end
            scnt = (scnt + 1) % S;
            d2 = d1;
            d1 = ain;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            upd();
            #1;
            chk("debounced", debounced_out, e_deb);
            chk("press", press_pulse, e_pr);
            chk("release", release_pulse, rl_exp());
            if (press_pulse[0]) np0++;
            if (release_pulse[0]) nr0++;
            if (press_pulse == 2'b11) nb++;
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) begin mc[i] = 0; mp[i] = 0; end
        rst = 1'b1; ain = '0;
        step(2);
        chk("reset_deb", debounced_out, 2'b00);
        rst = 1'b0;
        ain = 2'b01; np0 = 0;
        step(20);
        chk_i("single_press", np0, 1);
        chk("held_level", debounced_out, 2'b01);
        ain = 2'b00; nr0 = 0;
        step(5);
        chk("released_level", debounced_out, 2'b00);
`ifdef INPUT_COND_RELEASE_PULSE_EN
        chk_i("release_count", nr0, 1);
`else
        chk_i("release_count", nr0, 0);
`endif
        np0 = 0;
        ain = 2'b01; step(8);
        ain = 2'b00; step(4);
        chk_i("bounce_no_press", np0, 0);
        ain = 2'b01; step(24);
        chk_i("bounce_one_press", np0, 1);
        ain = 2'b00; step(8);
        ain = 2'b11; nb = 0;
        step(20);
        chk_i("both_same_cycle", nb, 1);
        chk("both_level", debounced_out, 2'b11);
        rst = 1'b1; nr0 = 0;
        step(1);
        chk("rst_drop", debounced_out, 2'b00);
        rst = 1'b0; nb = 0;
        step(20);
        chk_i("rst_no_release", nr0, 0);
        chk_i("repress_after_rst", nb, 1);
        for (int r = 0; r < 60; r++) begin
            ain = W'($urandom);
            step($urandom_range(1, 16));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
